mt_wb_arbiter: RTL and testbench

// - Write-side master for the per-thread register file in the barrel pipeline: merges ALU results and

---
 rtl/mt_pkg.sv | 24 ++
 rtl/mt_wb_fifo.sv | 79 +++++++
 rtl/mt_wb_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mt_wb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mt_pkg
// Description : Shared sizing constants and the register-file writeback entry
//               type used by decode (regfile), execute and the writeback
//               arbiter of the barrel pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package mt_pkg;

    localparam int NUM_THREADS  = 8;
    localparam int BITS_THREADS = $clog2(NUM_THREADS);
    localparam int DATA_WIDTH   = 32;
    localparam int REG_ADDR_W   = 5;

    // One pending register-file write: thread, destination register, value.
    typedef struct packed {
        logic [BITS_THREADS-1:0] tid;
        logic [REG_ADDR_W-1:0]   rd;
        logic [DATA_WIDTH-1:0]   data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/mt_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mt_wb_fifo
// Description : Synchronous FIFO of wb_entry_t holding load returns until the
//               regfile write port is free. The head entry is visible
//               combinationally while the FIFO is non-empty.
// Ports       : clk, rst_n (sync, active-low)
//               push, push_data  - enqueue (ignored when full)
//               pop              - dequeue head (ignored when empty)
//               head             - current head entry
//               full, empty      - derived from the registered count
//               count            - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module mt_wb_fifo
    import mt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wb_entry_t                push_data,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL  = (c_PTR_W + 1)'(DEPTH);

    wb_entry_t            r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;

    logic                 w_do_push;
    logic                 w_do_pop;

    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mt_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mt_wb_arbiter
// Description : Write-side master for the per-thread register file. ALU
//               results own the single write port; load returns wait in a
//               small FIFO and drain when the ALU leaves the slot free. Keeps
//               one outstanding-load bit per thread for fetch, and raises an
//               advisory stall_req when buffered loads have been starved.
// Ports       : clk, rst_n (sync, active-low)
//               alu_valid/alu_tid/alu_rd/alu_data  - ALU result, no backpressure
//               ld_issue/ld_issue_tid              - load issued, sets pending
//               ld_valid/ld_ready/ld_tid/ld_rd/ld_data - load response
//               write_enable/tid_write/a3/wd3      - registered regfile write
//               ld_pending                         - per-thread outstanding load
//               stall_req                          - request for an ALU bubble
// Revision    : 1.0 - initial release
// ============================================================================
module mt_wb_arbiter
    import mt_pkg::*;
#(
    parameter int NUM_THREADS  = mt_pkg::NUM_THREADS,
    parameter int BITS_THREADS = $clog2(NUM_THREADS),
    parameter int DATA_WIDTH   = mt_pkg::DATA_WIDTH,
    parameter int LQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alu_valid,
    input  logic [BITS_THREADS-1:0] alu_tid,
    input  logic [REG_ADDR_W-1:0]   alu_rd,
    input  logic [DATA_WIDTH-1:0]   alu_data,
    input  logic                    ld_issue,
    input  logic [BITS_THREADS-1:0] ld_issue_tid,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [BITS_THREADS-1:0] ld_tid,
    input  logic [REG_ADDR_W-1:0]   ld_rd,
    input  logic [DATA_WIDTH-1:0]   ld_data,
    output logic                    write_enable,
    output logic [BITS_THREADS-1:0] tid_write,
    output logic [REG_ADDR_W-1:0]   a3,
    output logic [DATA_WIDTH-1:0]   wd3,
    output logic [NUM_THREADS-1:0]  ld_pending,
    output logic                    stall_req
);

    localparam int                 c_CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // Load-return FIFO
    // ------------------------------------------------------------------
    wb_entry_t                  w_push_entry;
    wb_entry_t                  w_head;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic [$clog2(LQ_DEPTH):0]  w_fifo_count;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_alu_take;
    logic                       w_lq_nonempty;

    assign w_push_entry = '{tid: ld_tid, rd: ld_rd, data: ld_data};

    // Ready comes from the registered count only, so a same-cycle pop
    // never opens a slot for the response presented in that cycle.
    assign ld_ready      = !w_fifo_full;
    assign w_push        = ld_valid && !w_fifo_full;

    // Writes to r0 are architecturally discarded, so such an ALU result
    // does not occupy the write port and a load may drain instead.
    assign w_alu_take    = alu_valid && (alu_rd != '0);
    assign w_pop         = !w_alu_take && !w_fifo_empty;
    assign w_lq_nonempty = (w_fifo_count != '0);

    mt_wb_fifo #(
        .DEPTH     (LQ_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // Registered regfile write port
    // ------------------------------------------------------------------
    logic                    r_write_enable;
    logic [BITS_THREADS-1:0] r_tid_write;
    logic [REG_ADDR_W-1:0]   r_a3;
    logic [DATA_WIDTH-1:0]   r_wd3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_write_enable <= 1'b0;
            r_tid_write    <= '0;
            r_a3           <= '0;
            r_wd3          <= '0;
        end else if (w_alu_take) begin
            r_write_enable <= 1'b1;
            r_tid_write    <= alu_tid;
            r_a3           <= alu_rd;
            r_wd3          <= alu_data;
        end else if (w_pop) begin
            // A load to r0 is still consumed (and clears pending) but
            // produces no write; the address/data lines keep their values.
            r_write_enable <= (w_head.rd != '0);
            if (w_head.rd != '0) begin
                r_tid_write <= w_head.tid;
                r_a3        <= w_head.rd;
                r_wd3       <= w_head.data;
            end
        end else begin
            r_write_enable <= 1'b0;
        end
    end

    assign write_enable = r_write_enable;
    assign tid_write    = r_tid_write;
    assign a3           = r_a3;
    assign wd3          = r_wd3;

    // ------------------------------------------------------------------
    // Per-thread outstanding-load bits
    // ------------------------------------------------------------------
    logic [NUM_THREADS-1:0] r_ld_pending;
    logic [NUM_THREADS-1:0] w_set_mask;
    logic [NUM_THREADS-1:0] w_clr_mask;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (ld_issue) begin
            w_set_mask[ld_issue_tid] = 1'b1;
        end
        if (w_pop) begin
            w_clr_mask[w_head.tid] = 1'b1;
        end
    end

    // Set is applied after clear so a new issue wins over a same-cycle pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ld_pending <= '0;
        end else begin
            r_ld_pending <= (r_ld_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign ld_pending = r_ld_pending;

    // ------------------------------------------------------------------
    // Starvation counter and stall request
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_starve_cnt;
    logic [c_CNT_W-1:0] w_starve_next;
    logic               r_stall_req;

    always_comb begin
        w_starve_next = r_starve_cnt;
        if (!w_lq_nonempty || w_pop) begin
            w_starve_next = '0;
        end else if (w_alu_take && (r_starve_cnt != c_STARVE_MAX)) begin
            w_starve_next = r_starve_cnt + 1'b1;
        end
    end

    // stall_req is registered alongside the counter so it always mirrors
    // the counter's saturated state without an extra cycle of lag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_stall_req  <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_next;
            r_stall_req  <= (w_starve_next == c_STARVE_MAX);
        end
    end

    assign stall_req = r_stall_req;

endmodule
`default_nettype wire

// File: tb/tb_mt_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mt_wb_arbiter
// Description : Self-checking bench for mt_wb_arbiter. The stimulus process
//               drives directed vectors and, at each rising edge, pushes the
//               expected regfile writes into a scoreboard queue; a separate
//               monitor pops and compares whenever write_enable is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mt_wb_arbiter;
    import mt_pkg::*;

    localparam int NT = 8;
    localparam int LQ = 4;
    localparam int SL = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [2:0]  alu_tid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [2:0]  ld_issue_tid;
    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  ld_tid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        write_enable;
    logic [2:0]  tid_write;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [7:0]  ld_pending;
    logic        stall_req;

    always #5 clk = ~clk;

    mt_wb_arbiter #(
        .NUM_THREADS  (NT),
        .BITS_THREADS (3),
        .DATA_WIDTH   (32),
        .LQ_DEPTH     (LQ),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_tid      (alu_tid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .ld_issue     (ld_issue),
        .ld_issue_tid (ld_issue_tid),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_tid       (ld_tid),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .write_enable (write_enable),
        .tid_write    (tid_write),
        .a3           (a3),
        .wd3          (wd3),
        .ld_pending   (ld_pending),
        .stall_req    (stall_req)
    );

    // Scoreboard of expected writes and a behavioural model of the buffer.
    wb_entry_t exp_q[$];
    wb_entry_t mlq[$];
    logic [7:0] m_pending = '0;
    int         m_starve  = 0;
    logic       m_stall   = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_tid = '0; alu_rd = '0; alu_data = '0;
        ld_issue  = 1'b0; ld_issue_tid = '0;
        ld_valid  = 1'b0; ld_tid = '0; ld_rd = '0; ld_data = '0;
    endtask

    // Advance one clock; update the model from the inputs seen at the edge.
    task automatic tick();
        bit        take;
        bit        nonempty;
        bit        room;
        bit        popped;
        wb_entry_t h;
        logic [7:0] clr;
        @(posedge clk);
        if (!rst_n) begin
            mlq.delete();
            exp_q.delete();
            m_pending = '0;
            m_starve  = 0;
            m_stall   = 1'b0;
        end else begin
            take     = alu_valid && (alu_rd != 5'd0);
            nonempty = (mlq.size() > 0);
            room     = (mlq.size() < LQ);
            popped   = 1'b0;
            clr      = '0;
            if (take) begin
                check("alu_thread_not_pending", m_pending[alu_tid], 1'b0);
                exp_q.push_back(wb_entry_t'{tid: alu_tid, rd: alu_rd, data: alu_data});
            end else if (nonempty) begin
                h = mlq.pop_front();
                popped = 1'b1;
                clr[h.tid] = 1'b1;
                if (h.rd != 5'd0) exp_q.push_back(h);
            end
            if (ld_valid && room)
                mlq.push_back(wb_entry_t'{tid: ld_tid, rd: ld_rd, data: ld_data});
            m_pending = (m_pending & ~clr) | (ld_issue ? (8'd1 << ld_issue_tid) : 8'd0);
            if (!nonempty || popped) m_starve = 0;
            else if (take && m_starve < SL) m_starve++;
            m_stall = (m_starve == SL);
        end
        #1;
    endtask

    // Monitor: compares registered outputs against the model every cycle.
    initial begin
        wb_entry_t e;
        forever begin
            @(negedge clk);
            check("ld_ready", ld_ready, (mlq.size() < LQ));
            check("ld_pending", ld_pending, m_pending);
            check("stall_req", stall_req, m_stall);
            if (write_enable) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", write_enable, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_tid", tid_write, e.tid);
                    check("wr_a3", a3, e.rd);
                    check("wr_wd3", wd3, e.data);
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("missing_write", write_enable, 1'b1);
            end
        end
    end

    initial begin
        int k;
        bit acc;
        rst_n = 1'b0;
        idle();
        tick(); tick();
        @(negedge clk);
        check("rst_we", write_enable, 1'b0);
        check("rst_tid", tid_write, 3'd0);
        check("rst_a3", a3, 5'd0);
        check("rst_wd3", wd3, 32'd0);
        check("rst_pending", ld_pending, 8'd0);
        check("rst_stall", stall_req, 1'b0);
        check("rst_ready", ld_ready, 1'b1);
        rst_n = 1'b1;

        // ALU write appears the following cycle.
        alu_valid = 1'b1; alu_tid = 3'd3; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick(); idle();
        @(negedge clk);
        check("alu_we", write_enable, 1'b1);
        check("alu_tid", tid_write, 3'd3);
        check("alu_a3", a3, 5'd5);
        check("alu_wd3", wd3, 32'hDEADBEEF);

        // Load issue / return latency and pending bit.
        ld_issue = 1'b1; ld_issue_tid = 3'd2;
        tick(); idle();
        @(negedge clk);
        check("pend_set2", ld_pending, 8'h04);
        ld_valid = 1'b1; ld_tid = 3'd2; ld_rd = 5'd7; ld_data = 32'h1234;
        tick(); idle();
        @(negedge clk);
        check("ld_no_bypass", write_enable, 1'b0);
        check("pend_held2", ld_pending, 8'h04);
        tick();
        @(negedge clk);
        check("ld_we", write_enable, 1'b1);
        check("ld_a3", a3, 5'd7);
        check("ld_wd3", wd3, 32'h1234);
        check("pend_clr2", ld_pending, 8'h00);

        // Starvation: ALU every cycle, five load responses offered.
        k = 0;
        for (int i = 0; i < 12; i++) begin
            alu_valid = 1'b1; alu_tid = (i % 2 == 0) ? 3'd6 : 3'd7;
            alu_rd = 5'(1 + i); alu_data = 32'hA000 + 32'(i);
            ld_valid = (k < 5); ld_tid = 3'(k); ld_rd = 5'(10 + k); ld_data = 32'hB000 + 32'(k);
            acc = ld_valid && (mlq.size() < LQ);
            tick();
            if (acc) k++;
            @(negedge clk);
            if (i == 3) check("full_not_ready", ld_ready, 1'b0);
            if (i == 7) check("stall_before_limit", stall_req, 1'b0);
            if (i == 8) check("stall_at_limit", stall_req, 1'b1);
        end
        alu_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ld_valid = (k < 5); ld_tid = 3'(k); ld_rd = 5'(10 + k); ld_data = 32'hB000 + 32'(k);
            acc = ld_valid && (mlq.size() < LQ);
            tick();
            if (acc) k++;
            @(negedge clk);
            if (i == 0) check("stall_drop_on_pop", stall_req, 1'b0);
            if (i == 0) check("drain_first_data", wd3, 32'hB000);
        end
        idle();

        // ALU to r0 produces no write.
        alu_valid = 1'b1; alu_tid = 3'd3; alu_rd = 5'd0; alu_data = 32'hFFFF;
        tick(); idle();
        @(negedge clk);
        check("alu_r0_no_we", write_enable, 1'b0);

        // Load to r0: no write, pending cleared.
        ld_issue = 1'b1; ld_issue_tid = 3'd4;
        tick(); idle();
        ld_valid = 1'b1; ld_tid = 3'd4; ld_rd = 5'd0; ld_data = 32'h55;
        tick(); idle();
        @(negedge clk);
        check("pend_set4", ld_pending, 8'h10);
        tick();
        @(negedge clk);
        check("ld_r0_no_we", write_enable, 1'b0);
        check("pend_clr4", ld_pending, 8'h00);

        // Same-cycle re-issue and pop for thread 1: set wins.
        ld_issue = 1'b1; ld_issue_tid = 3'd1;
        tick(); idle();
        ld_valid = 1'b1; ld_tid = 3'd1; ld_rd = 5'd3; ld_data = 32'h77;
        tick(); idle();
        ld_issue = 1'b1; ld_issue_tid = 3'd1;
        tick(); idle();
        @(negedge clk);
        check("set_wins_pend", ld_pending, 8'h02);
        check("set_wins_a3", a3, 5'd3);
        ld_valid = 1'b1; ld_tid = 3'd1; ld_rd = 5'd3; ld_data = 32'h88;
        tick(); idle();
        tick();
        @(negedge clk);
        check("pend_clr1", ld_pending, 8'h00);

        // Reset with three buffered loads and pending bits.
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_tid = 3'd6; alu_rd = 5'd2; alu_data = 32'hC000 + 32'(i);
            ld_issue = (i < 3); ld_issue_tid = 3'(i);
            ld_valid = (i > 0); ld_tid = 3'(i - 1); ld_rd = 5'(20 + i); ld_data = 32'hD000 + 32'(i);
            tick();
        end
        idle();
        @(negedge clk);
        check("pre_rst_pend", ld_pending, 8'h07);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("mid_rst_we", write_enable, 1'b0);
        check("mid_rst_tid", tid_write, 3'd0);
        check("mid_rst_a3", a3, 5'd0);
        check("mid_rst_wd3", wd3, 32'd0);
        check("mid_rst_pend", ld_pending, 8'd0);
        check("mid_rst_stall", stall_req, 1'b0);
        check("mid_rst_ready", ld_ready, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        @(negedge clk);
        check("post_rst_no_we", write_enable, 1'b0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
